// File: rtl/fetch_if.sv
// Fetch-side bus between the fetch controller, instruction memory and decode.
// The master modport is the fetch controller; the slave modport is its environment.
interface fetch_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] pc_val;
    logic [DW-1:0] id;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;

    modport master (
        output pc_val, instr, instr_pc, instr_valid,
        input  id, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  pc_val, instr, instr_pc, instr_valid,
        output id, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, captures memory words into a 2-entry
// buffer drained by decode, and handles start, redirect/flush, HALT and back-pressure.
module fetch_controller #(
    parameter int              AW        = 5,
    parameter int              DW        = 32,
    parameter logic [AW-1:0]   RESET_PC  = '0,
    parameter logic [DW-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start_i,
    output logic      busy_o,
    output logic      halted_o,
    fetch_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          pc_q, pc_d;
    logic [1:0]             count_q, count_d;
    logic                   head_q, head_d;
    logic                   tail_q, tail_d;
    logic [1:0][DW-1:0]     buf_instr_q;
    logic [1:0][AW-1:0]     buf_pc_q;

    logic                   deq_s;
    logic                   enq_s;
    logic                   flush_s;
    logic                   fetch_ok_s;

    assign deq_s      = (count_q != 2'd0) & bus.instr_ready;
    assign fetch_ok_s = (count_q < 2'd2) | deq_s;

    // Next-state, PC and buffer-pointer logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        enq_s   = 1'b0;
        flush_s = 1'b0;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.redirect) begin
                    flush_s = 1'b1;
                    pc_d    = bus.redirect_pc;
                end else if (fetch_ok_s) begin
                    if (bus.id == HALT_WORD) begin
                        state_d = ST_HALT;
                    end else begin
                        enq_s = 1'b1;
                        pc_d  = pc_q + AW'(1);
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_HALT: begin
                if (bus.redirect) begin
                    flush_s = 1'b1;
                    pc_d    = bus.redirect_pc;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect discards everything, including a same-cycle dequeue
        if (flush_s) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            count_d = count_q + {1'b0, enq_s} - {1'b0, deq_s};
            head_d  = head_q ^ deq_s;
            tail_d  = tail_q ^ enq_s;
        end
    end

    // State, PC and buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            count_q     <= 2'd0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            if (enq_s) begin
                buf_instr_q[tail_q] <= bus.id;
                buf_pc_q[tail_q]    <= pc_q;
            end
        end
    end

    assign bus.pc_val      = pc_q;
    assign bus.instr_valid = (count_q != 2'd0);
    assign bus.instr       = (count_q != 2'd0) ? buf_instr_q[head_q] : '0;
    assign bus.instr_pc    = (count_q != 2'd0) ? buf_pc_q[head_q] : '0;
    assign busy_o          = (state_q == ST_RUN);
    assign halted_o        = (state_q == ST_HALT);

endmodule
